// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: RAW/WAW/structural stall detection, forwarding selects,
// and a shift-register model of the fixed-latency multiplier pipeline.
`timescale 1ns/1ps
module hazard_scoreboard #(
   parameter int NUM_RD_PORTS = 2,
   parameter int MULT_LAT     = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [5*NUM_RD_PORTS-1:0]       id_rd_addr,
   input  logic                            id_wr_valid,
   input  logic [4:0]                      id_wr_addr,
   input  logic                            id_mult,
   input  logic                            ex_wr_valid,
   input  logic [4:0]                      ex_wr_addr,
   input  logic                            mem_wr_valid,
   input  logic [4:0]                      mem_wr_addr,
   input  logic                            wb_wr_valid,
   input  logic [4:0]                      wb_wr_addr,
   output logic [2*NUM_RD_PORTS-1:0]       fwd_sel,
   output logic                            stall,
   output logic                            mult_wb_valid,
   output logic [4:0]                      mult_wb_addr,
   output logic [$clog2(MULT_LAT+1)-1:0]   mult_inflight
);

   localparam int CNT_W = $clog2(MULT_LAT+1);
   // Entry whose retirement would coincide with an ALU writeback issued now.
   localparam int STRUCT_IDX = (MULT_LAT >= 3) ? MULT_LAT-3 : 0;

   logic [MULT_LAT-1:0]     vld_reg;
   logic [MULT_LAT-1:0]     vld_next;
   logic [4:0]              addr_reg  [MULT_LAT];
   logic [4:0]              addr_next [MULT_LAT];
   logic [CNT_W-1:0]        cnt_reg;
   logic [CNT_W-1:0]        cnt_next;

   logic [NUM_RD_PORTS-1:0] raw_ex;
   logic [NUM_RD_PORTS-1:0] raw_mult;
   logic                    waw_hit;
   logic                    struct_mult;
   logic                    struct_alu;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
         logic [4:0] rd;
         logic       rd_nz;
         logic       pend_hit;
         logic [1:0] sel;

         assign rd    = id_rd_addr[5*gi +: 5];
         assign rd_nz = (rd != 5'd0);
         assign raw_ex[gi] = rd_nz && ex_wr_valid && (ex_wr_addr == rd);

         // The last entry is excluded: it retires this cycle and is forwarded instead.
         always_comb begin
            pend_hit = 1'b0;
            for (int j = 0; j < MULT_LAT-1; j++) begin
               if (vld_reg[j] && (addr_reg[j] == rd)) begin
                  pend_hit = 1'b1;
               end
            end
         end
         assign raw_mult[gi] = rd_nz && pend_hit;

         always_comb begin
            sel = 2'b00;
            if (rd_nz && mem_wr_valid && (mem_wr_addr == rd)) begin
               sel = 2'b10;
            end else if (rd_nz && vld_reg[MULT_LAT-1] && (addr_reg[MULT_LAT-1] == rd)) begin
               sel = 2'b11;
            end else if (rd_nz && wb_wr_valid && (wb_wr_addr == rd)) begin
               sel = 2'b01;
            end
         end
         assign fwd_sel[2*gi +: 2] = sel;
      end
   endgenerate

   always_comb begin
      waw_hit = 1'b0;
      for (int j = 0; j < MULT_LAT-1; j++) begin
         if (vld_reg[j] && (addr_reg[j] == id_wr_addr)) begin
            waw_hit = 1'b1;
         end
      end
   end

   assign struct_mult = id_mult && vld_reg[MULT_LAT-2] && wb_wr_valid;
   assign struct_alu  = !id_mult && id_wr_valid && vld_reg[STRUCT_IDX];

   assign stall = (|raw_ex) || (|raw_mult) ||
                  (id_wr_valid && (id_wr_addr != 5'd0) && waw_hit) ||
                  struct_mult || struct_alu;

   // Shift advances every cycle; a stalled issue inserts a bubble.
   always_comb begin
      vld_next[0]  = id_mult && !stall;
      addr_next[0] = (id_mult && !stall) ? id_wr_addr : 5'd0;
      for (int j = 1; j < MULT_LAT; j++) begin
         vld_next[j]  = vld_reg[j-1];
         addr_next[j] = addr_reg[j-1];
      end
      cnt_next = '0;
      for (int j = 0; j < MULT_LAT; j++) begin
         cnt_next = cnt_next + CNT_W'(vld_next[j]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_reg <= '0;
         for (int j = 0; j < MULT_LAT; j++) begin
            addr_reg[j] <= 5'd0;
         end
         cnt_reg <= '0;
      end else begin
         vld_reg <= vld_next;
         for (int j = 0; j < MULT_LAT; j++) begin
            addr_reg[j] <= addr_next[j];
         end
         cnt_reg <= cnt_next;
      end
   end

   assign mult_wb_valid = vld_reg[MULT_LAT-1];
   assign mult_wb_addr  = addr_reg[MULT_LAT-1];
   assign mult_inflight = cnt_reg;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have these parameters:
- NUM_RD_PORTS, default 2, number of ID-stage register read ports.
- MULT_LAT, default 4, multiplier pipeline depth in cycles (>=2).
REQ-002 The block SHALL have these ports:
- i_clk  in  1  sole clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- id_rd_addr  in  5*NUM_RD_PORTS  ID read addresses, port k at bits [5k+4:5k].
- id_wr_valid  in  1  ID instruction writes a register.
- id_wr_addr  in  5  ID destination register.
- id_mult  in  1  ID instruction issues to the multiplier.
- ex_wr_valid, mem_wr_valid, wb_wr_valid  in  1 each  stage writes a register.
- ex_wr_addr, mem_wr_addr, wb_wr_addr  in  5 each  stage destination register.
- fwd_sel  out  2*NUM_RD_PORTS  per-port select: 00 RF, 01 WB, 10 MEM, 11 MULT.
- stall  out  1  hold IF/ID; bubble into EX.
- mult_wb_valid  out  1  multiplier result retires this cycle.
- mult_wb_addr  out  5  retiring destination register.
- mult_inflight  out  $clog2(MULT_LAT+1)  count of valid multiplier stages.

Function
REQ-003 The block SHALL track the multiplier in a MULT_LAT-entry shift register of {valid, addr}, advancing every cycle regardless of stall.
REQ-004 Entry 0 SHALL load {1, id_wr_addr} when id_mult=1 and stall=0; otherwise it SHALL load {0, 0}.
REQ-005 mult_wb_valid and mult_wb_addr SHALL equal the last entry (index MULT_LAT-1).
- Result latency is exactly MULT_LAT cycles after the accepted issue edge.
REQ-006 A pending multiplier write to register r SHALL mean a valid entry with addr=r at index 0..MULT_LAT-2.
REQ-007 The block SHALL assert stall for the current cycle if any of these hold:
- (a) RAW on EX: any read port addr!=0 and ex_wr_valid and ex_wr_addr equals it.
- (b) RAW on multiplier: any read port addr!=0 matches a pending multiplier write.
- (c) WAW: id_wr_valid and id_wr_addr!=0 and id_wr_addr matches a pending multiplier write.
- (d) Structural: id_mult=1 and entry MULT_LAT-2 is valid and wb_wr_valid will collide; stall when id_mult=0 and id_wr_valid=1 and entry MULT_LAT-3 is valid, so ALU writeback never coincides with mult_wb_valid (MULT_LAT>=3; for MULT_LAT=2, entry 0).
REQ-008 Per read port, fwd_sel SHALL be chosen by priority: MEM match -> 10; else last-entry multiplier match -> 11; else WB match -> 01; else 00.
- Every match requires address !=0 and the corresponding valid signal.
REQ-009 fwd_sel SHALL be computed even while stall=1.
- The consumer ignores fwd_sel during stall.
REQ-010 Register 0 SHALL never cause a match, stall, or non-00 select.
REQ-011 mult_inflight SHALL equal the population count of valid entries, updated registered with the shift.
REQ-012 stall SHALL be purely combinational from inputs and current state, with no registered stall history.
REQ-013 Simultaneous accepted issue and retire SHALL leave mult_inflight unchanged.

Reset
REQ-014 While i_rst_n=0, all shift entries SHALL be {0,0}, and mult_wb_valid=0, mult_wb_addr=0, mult_inflight=0.
- fwd_sel and stall follow REQ-007/008 from inputs only.
REQ-015 Reset asserted mid-operation SHALL discard all in-flight multiplies with no retire pulse.

Verification
REQ-016 The bench SHALL cover these scenarios:
- EX-use: ex_wr_valid=1, ex_wr_addr=8, id port0 addr=8 -> stall=1. Same with addr 0 -> stall=0, fwd_sel=00.
- MEM/WB priority: mem and wb both write 9, port1 reads 9 -> fwd_sel[3:2]=10. Only wb writes 9 -> 01.
- Multiplier RAW (MULT_LAT=4): issue id_mult to r12 at cycle 0. Port0 reads r12 -> stall=1 in cycles 1-3. Cycle 4: mult_wb_valid=1, mult_wb_addr=12, stall=0, fwd_sel[1:0]=11.
- WAW: r12 pending, ID writes r12 with no reads -> stall=1 until the retire cycle.
- Back-to-back: 4 accepted issues to r1..r4 -> mult_inflight reaches 4, then retire pulses addr 1,2,3,4 on consecutive cycles. An id_mult during stall is not accepted (no entry loaded).
- Reset mid-flight: i_rst_n=0 with 3 entries valid -> mult_inflight=0 immediately. After release, no mult_wb_valid pulse occurs.
